// File: rtl/imsic_intp_file_ctrl.sv
// imsic_intp_file_ctrl
//   Per-hart IMSIC interrupt-file controller. It accepts MSI writes (file, identity)
//   and keeps one pending vector per interrupt file. A time-multiplexed scanner
//   publishes the lowest nonzero pending&enabled identity per file as topei.
//   A CSR claim (topei read-and-clear) clears the claimed pending bit.
//   Optional build macro: IMSIC_MSI_FIFO_EN replaces the single MSI stage register
//   with a 4-entry in-order FIFO.
module imsic_intp_file_ctrl #(
  parameter  int NrIntpFiles = 3,
  parameter  int NrSources   = 64,
  parameter  int ScanWidth   = 32,
  localparam int IdW         = $clog2(NrSources),
  localparam int FileW       = (NrIntpFiles > 1) ? $clog2(NrIntpFiles) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           msi_valid_i,
  output logic                           msi_ready_o,
  input  logic [FileW-1:0]               msi_file_i,
  input  logic [IdW-1:0]                 msi_id_i,
  input  logic [NrIntpFiles*NrSources-1:0] eie_i,
  input  logic [NrIntpFiles-1:0]         eidelivery_i,
  input  logic                           claim_valid_i,
  input  logic [FileW-1:0]               claim_file_i,
  output logic [NrIntpFiles*IdW-1:0]     topei_o,
  output logic [NrIntpFiles-1:0]         irq_o
);

  localparam int                NrChunks   = NrSources / ScanWidth;
  localparam int                ChunkW     = (NrChunks > 1) ? $clog2(NrChunks) : 1;
  localparam logic [FileW:0]    NrFilesExt = (FileW+1)'(NrIntpFiles);
  localparam logic [FileW-1:0]  LastFile   = FileW'(NrIntpFiles - 1);
  localparam logic [ChunkW-1:0] LastChunk  = ChunkW'(NrChunks - 1);

  typedef enum logic {SCAN, PUBLISH} scan_state_e;

  // Architectural state.
  logic [NrSources-1:0] pending_q [NrIntpFiles];
  logic [NrSources-1:0] pending_d [NrIntpFiles];
  logic [IdW-1:0]       topei_q   [NrIntpFiles];
  logic [IdW-1:0]       topei_d   [NrIntpFiles];

  // Scanner state.
  scan_state_e       state_q, state_d;
  logic [FileW-1:0]  file_q, file_d;
  logic [ChunkW-1:0] chunk_q, chunk_d;
  logic [IdW-1:0]    best_q, best_d;
  logic              publish;

  // Ingress head (oldest accepted MSI not yet applied).
  logic             head_valid;
  logic [FileW-1:0] head_file;
  logic [IdW-1:0]   head_id;
  logic             head_target_ok;
  logic             head_drain;
  logic             msi_push;

  // Claim decode.
  logic             claim_file_ok;
  logic [FileW-1:0] claim_idx;
  logic             claim_hit;
  logic             collision;

  // Per-file enables viewed as chunks so the scanner can select with narrow indices.
  logic [NrChunks-1:0][ScanWidth-1:0] eie_w [NrIntpFiles];

  for (genvar f = 0; f < NrIntpFiles; f++) begin : g_file
    assign eie_w[f]                 = eie_i[f*NrSources +: NrSources];
    assign topei_o[f*IdW +: IdW]    = topei_q[f];
    assign irq_o[f]                 = eidelivery_i[f] && (topei_q[f] != '0);
  end

  // A claim only acts on a real file whose published identity is nonzero.
  assign claim_file_ok = ({1'b0, claim_file_i} < NrFilesExt);
  assign claim_idx     = claim_file_ok ? claim_file_i : '0;
  assign claim_hit     = claim_valid_i && claim_file_ok && (topei_q[claim_idx] != '0);

  // Writes with id 0 or a nonexistent file are consumed without touching state.
  assign head_target_ok = head_valid && (head_id != '0) && ({1'b0, head_file} < NrFilesExt);
  // A claim presented to the head's file holds the head for that cycle so the
  // pending vector of one file is never set and cleared in the same cycle.
  assign collision      = claim_valid_i && claim_file_ok && head_target_ok &&
                          (head_file == claim_file_i);
  assign head_drain     = head_valid && !collision;
  assign msi_push       = msi_valid_i && msi_ready_o;

`ifdef IMSIC_MSI_FIFO_EN
  logic [FileW-1:0] fifo_file_q [4];
  logic [IdW-1:0]   fifo_id_q   [4];
  logic [1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [2:0]       cnt_q, cnt_d;

  assign head_valid  = (cnt_q != 3'd0);
  assign head_file   = fifo_file_q[rptr_q];
  assign head_id     = fifo_id_q[rptr_q];
  assign msi_ready_o = rst_ni && (cnt_q != 3'd4);

  // FIFO pointer/occupancy next state.
  always_comb begin
    wptr_d = wptr_q + 2'(msi_push);
    rptr_d = rptr_q + 2'(head_drain);
    cnt_d  = cnt_q + 3'(msi_push) - 3'(head_drain);
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // FIFO storage.
  // NOTE: the entry array has no reset; occupancy is reset, so stale entries are never read.
  always_ff @(posedge clk_i) begin
    if (msi_push) begin
      fifo_file_q[wptr_q] <= msi_file_i;
      fifo_id_q[wptr_q]   <= msi_id_i;
    end
  end
`else
  logic             stage_valid_q, stage_valid_d;
  logic [FileW-1:0] stage_file_q, stage_file_d;
  logic [IdW-1:0]   stage_id_q, stage_id_d;

  assign head_valid  = stage_valid_q;
  assign head_file   = stage_file_q;
  assign head_id     = stage_id_q;
  assign msi_ready_o = rst_ni && (!stage_valid_q || head_drain);

  // Stage register next state: load on transfer, empty once drained.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    stage_valid_d = stage_valid_q && !head_drain;
    stage_file_d  = stage_file_q;
    stage_id_d    = stage_id_q;
    if (msi_push) begin
      stage_valid_d = 1'b1;
      stage_file_d  = msi_file_i;
      stage_id_d    = msi_id_i;
    end
  end

  // Stage register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stage_valid_q <= 1'b0;
      stage_file_q  <= '0;
      stage_id_q    <= '0;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_file_q  <= stage_file_d;
      stage_id_q    <= stage_id_d;
    end
  end
`endif

  // Scanner datapath: lowest pending&enabled id in the current chunk (id 0 excluded).
  logic [NrChunks-1:0][ScanWidth-1:0] pend_w;
  logic [ScanWidth-1:0]               cand;
  logic                               found;
  logic [IdW-1:0]                     found_id;

  always_comb begin
    pend_w   = pending_q[file_q];
    cand     = pend_w[chunk_q] & eie_w[file_q][chunk_q];
    found    = 1'b0;
    found_id = '0;
    if (chunk_q == '0) cand[0] = 1'b0;
    for (int i = 0; i < ScanWidth; i++) begin
      if (cand[i] && !found) begin
        found    = 1'b1;
        found_id = IdW'(int'(chunk_q) * ScanWidth + i);
      end
    end
  end

  // Scanner FSM: SCAN walks the chunks of one file, PUBLISH writes its result.
  always_comb begin
    state_d = state_q;
    file_d  = file_q;
    chunk_d = chunk_q;
    best_d  = best_q;
    publish = 1'b0;
    if (claim_hit && (claim_idx == file_q)) begin
      // The partial result may hold the identity being claimed: start this file over.
      state_d = SCAN;
      chunk_d = '0;
      best_d  = '0;
    end else begin
      case (state_q)
        SCAN: begin
          if ((best_q == '0) && found) best_d = found_id;
          if (chunk_q == LastChunk) begin
            chunk_d = '0;
            state_d = PUBLISH;
          end else begin
            chunk_d = chunk_q + 1'b1;
          end
        end
        PUBLISH: begin
          publish = 1'b1;
          best_d  = '0;
          file_d  = (file_q == LastFile) ? '0 : file_q + 1'b1;
          state_d = SCAN;
        end
        default: state_d = SCAN;
      endcase
    end
  end

  // Pending and topei next state; a claim overrides a same-cycle publish.
  always_comb begin
    pending_d = pending_q;
    topei_d   = topei_q;
    if (head_drain && head_target_ok) pending_d[head_file][head_id] = 1'b1;
    if (publish) topei_d[file_q] = best_q;
    if (claim_hit) begin
      pending_d[claim_idx][topei_q[claim_idx]] = 1'b0;
      topei_d[claim_idx]                       = '0;
    end
  end

  // State registers for pending bits, published identities and the scanner.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pending_q <= '{default: '0};
      topei_q   <= '{default: '0};
      state_q   <= SCAN;
      file_q    <= '0;
      chunk_q   <= '0;
      best_q    <= '0;
    end else begin
      pending_q <= pending_d;
      topei_q   <= topei_d;
      state_q   <= state_d;
      file_q    <= file_d;
      chunk_q   <= chunk_d;
      best_q    <= best_d;
    end
  end

endmodule

// File: tb/tb_imsic_intp_file_ctrl.sv
// Self-checking bench for imsic_intp_file_ctrl (default parameters).
module tb_imsic_intp_file_ctrl;

  localparam int NF  = 3;
  localparam int NS  = 64;
  localparam int IDW = 6;
  localparam int FW  = 2;
  localparam int PUB_BOUND = 19;  // worst-case MSI accept -> topei visible

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              msi_valid = 1'b0;
  logic              msi_ready;
  logic [FW-1:0]     msi_file = '0;
  logic [IDW-1:0]    msi_id = '0;
  logic [NS-1:0]     eie_a [NF];
  logic [NF*NS-1:0]  eie;
  logic [NF-1:0]     eidelivery = '0;
  logic              claim_valid = 1'b0;
  logic [FW-1:0]     claim_file = '0;
  logic [NF*IDW-1:0] topei;
  logic [NF-1:0]     irq;
  logic [IDW-1:0]    top_a [NF];

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [FW-1:0]  file;
    logic [IDW-1:0] id;
    bit             en;
    bit             del;
    int             exp_topei;
    bit             exp_irq;
  } vec_t;

  vec_t vecs [7];
  vec_t exp_q [$];
  int   exp_ids [$];

  always #5 clk = ~clk;

  assign eie = {eie_a[2], eie_a[1], eie_a[0]};
  for (genvar g = 0; g < NF; g++) begin : g_top
    assign top_a[g] = topei[g*IDW +: IDW];
  end

  imsic_intp_file_ctrl dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .msi_valid_i   (msi_valid),
    .msi_ready_o   (msi_ready),
    .msi_file_i    (msi_file),
    .msi_id_i      (msi_id),
    .eie_i         (eie),
    .eidelivery_i  (eidelivery),
    .claim_valid_i (claim_valid),
    .claim_file_i  (claim_file),
    .topei_o       (topei),
    .irq_o         (irq)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int get_topei(input logic [FW-1:0] f);
    return int'(top_a[f]);
  endfunction

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_msi(input logic [FW-1:0] f, input logic [IDW-1:0] id, output int stalls);
    stalls    = 0;
    msi_valid = 1'b1;
    msi_file  = f;
    msi_id    = id;
    #1;
    while (!msi_ready && stalls < 50) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    if (!msi_ready) check("msi_accept_timeout", 0, 1);
    @(negedge clk);
    msi_valid = 1'b0;
  endtask

  task automatic do_claim(input logic [FW-1:0] f);
    claim_valid = 1'b1;
    claim_file  = f;
    @(negedge clk);
    claim_valid = 1'b0;
  endtask

  task automatic wait_nz(input logic [FW-1:0] f);
    for (int n = 0; n < PUB_BOUND && get_topei(f) == 0; n++) @(negedge clk);
  endtask

  task automatic wait_eq(input logic [FW-1:0] f, input int val);
    for (int n = 0; n < PUB_BOUND && get_topei(f) != val; n++) @(negedge clk);
  endtask

  // Pops expected identities for file f in order, claiming each once it is published.
  task automatic drain_claims(input logic [FW-1:0] f, input string tag);
    while (exp_ids.size() > 0) begin
      int e;
      e = exp_ids.pop_front();
      wait_eq(f, e);
      check($sformatf("%s_topei_%0d", tag, e), get_topei(f), e);
      do_claim(f);
      check($sformatf("%s_cleared_%0d", tag, e), get_topei(f), 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   stalls;
    vec_t v, e;

    for (int f = 0; f < NF; f++) eie_a[f] = '0;

    vecs[0] = '{2'd1, 6'd5,  1'b1, 1'b1, 5,  1'b1};  // basic delivery
    vecs[1] = '{2'd0, 6'd63, 1'b1, 1'b0, 63, 1'b0};  // top id, delivery off
    vecs[2] = '{2'd2, 6'd1,  1'b1, 1'b1, 1,  1'b1};  // lowest legal id
    vecs[3] = '{2'd0, 6'd32, 1'b1, 1'b1, 32, 1'b1};  // first id of second chunk
    vecs[4] = '{2'd1, 6'd20, 1'b0, 1'b1, 0,  1'b0};  // pending but disabled
    vecs[5] = '{2'd0, 6'd0,  1'b1, 1'b1, 0,  1'b0};  // id 0 dropped
    vecs[6] = '{2'd3, 6'd5,  1'b1, 1'b1, 0,  1'b0};  // nonexistent file dropped

    // Reset and idle.
    repeat (3) @(negedge clk);
    check("ready_in_reset", int'(msi_ready), 0);
    check("topei_in_reset", int'(topei), 0);
    check("irq_in_reset", int'(irq), 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_topei", int'(topei), 0);
    check("idle_irq", int'(irq), 0);
    check("idle_ready", int'(msi_ready), 1);

    // Table-driven single-identity vectors.
    foreach (vecs[i]) begin
      v = vecs[i];
      if (v.file < 2'd3) begin
        eie_a[v.file][v.id] = v.en;
        eidelivery[v.file]  = v.del;
      end
      send_msi(v.file, v.id, stalls);
      exp_q.push_back(v);
      e = exp_q.pop_front();
      if (e.file < 2'd3) begin
        wait_nz(e.file);
        check($sformatf("vec%0d_topei", i), get_topei(e.file), e.exp_topei);
        check($sformatf("vec%0d_irq", i), int'(irq[e.file]), int'(e.exp_irq));
        if (e.exp_topei != 0) begin
          do_claim(e.file);
          check($sformatf("vec%0d_claimed", i), get_topei(e.file), 0);
        end
      end else begin
        repeat (PUB_BOUND) @(negedge clk);
        check($sformatf("vec%0d_topei_all", i), int'(topei), 0);
      end
    end

    // Three pending ids in file 0, sent back to back; claimed in priority order.
    eie_a[0][40] = 1'b1;
    eie_a[0][7]  = 1'b1;
    eie_a[0][33] = 1'b1;
    send_msi(2'd0, 6'd40, stalls);
    check("b2b_stall_0", stalls, 0);
    send_msi(2'd0, 6'd7, stalls);
    check("b2b_stall_1", stalls, 0);
    send_msi(2'd0, 6'd33, stalls);
    check("b2b_stall_2", stalls, 0);
    exp_ids.push_back(7);
    exp_ids.push_back(33);
    exp_ids.push_back(40);
    drain_claims(2'd0, "file0");

    // Enabling an already pending id makes it visible.
    eie_a[1][20] = 1'b1;
    exp_ids.push_back(20);
    drain_claims(2'd1, "live_eie");

    // Claim colliding with a staged write to the same file.
    eie_a[2][3]  = 1'b1;
    eie_a[2][9]  = 1'b1;
    eie_a[2][12] = 1'b1;
    send_msi(2'd2, 6'd3, stalls);
    wait_eq(2'd2, 3);
    check("coll_pre_topei", get_topei(2'd2), 3);
    msi_valid = 1'b1;
    msi_file  = 2'd2;
    msi_id    = 6'd12;
    @(negedge clk);                 // id 12 now sits in the stage
    msi_id      = 6'd9;
    claim_valid = 1'b1;
    claim_file  = 2'd2;
`ifndef IMSIC_MSI_FIFO_EN
    #1;
    check("coll_ready_stalled", int'(msi_ready), 0);
`endif
    @(negedge clk);
    claim_valid = 1'b0;
    check("coll_claim_cleared", get_topei(2'd2), 0);
`ifndef IMSIC_MSI_FIFO_EN
    #1;
    check("coll_ready_released", int'(msi_ready), 1);
`endif
    @(negedge clk);
    msi_valid = 1'b0;
    exp_ids.push_back(9);
    exp_ids.push_back(12);
    drain_claims(2'd2, "coll");

`ifdef IMSIC_MSI_FIFO_EN
    // Six back-to-back MSIs while claims to the same file hold the FIFO head.
    begin
      int accepted;
      accepted = 0;
      for (int k = 10; k < 16; k++) eie_a[1][k] = 1'b1;
      claim_valid = 1'b1;
      claim_file  = 2'd1;
      for (int k = 0; k < 6; k++) begin
        msi_valid = 1'b1;
        msi_file  = 2'd1;
        msi_id    = IDW'(10 + k);
        #1;
        if (!msi_ready) break;
        @(negedge clk);
        accepted++;
      end
      check("fifo_accepted_before_full", accepted, 4);
      check("fifo_ready_full", int'(msi_ready), 0);
      claim_valid = 1'b0;
      for (int k = accepted; k < 6; k++) send_msi(2'd1, IDW'(10 + k), stalls);
      msi_valid = 1'b0;
      for (int k = 10; k < 16; k++) exp_ids.push_back(k);
      drain_claims(2'd1, "fifo");
    end
`endif

    repeat (PUB_BOUND) @(negedge clk);
    check("final_topei", int'(topei), 0);
    check("final_irq", int'(irq), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
